// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Requester indices, register codes and the wrap-around helper used by the pointer.
package regfile_pkg;

    typedef logic [1:0] reg_idx_t;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_ALU   = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_INPUT = 2'd2
    } requester_t;

    localparam reg_idx_t REG_A = 2'b00;
    localparam reg_idx_t REG_B = 2'b01;
    localparam reg_idx_t REG_C = 2'b10;
    localparam reg_idx_t REG_D = 2'b11;

    // Requester index following i, wrapping after the last requester.
    function automatic logic [1:0] next_req(input logic [1:0] i);
        return (i == 2'(NUM_REQ - 1)) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_req_buffer.sv
// One-entry holding buffer for a single write requester.
// load and clear are never asserted together: load needs empty, clear needs full.
module regfile_req_buffer
    import regfile_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  reg_idx_t   load_dest,
    input  logic [7:0] load_data,
    input  logic       clear,
    output logic       full,
    output reg_idx_t   dest,
    output logic [7:0] data
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            dest <= REG_A;
            data <= 8'h00;
        end else begin
            if (clear)
                full <= 1'b0;
            if (load) begin
                full <= 1'b1;
                dest <= load_dest;
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three buffered write requesters onto one register-file write port.
// Define REGFILE_ARB_RR_EN for round-robin priority; default is fixed ALU > LOAD > INPUT.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [2:0]  req_valid,
    input  logic [5:0]  req_dest,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    input  logic [1:0]  rd_sel_a,
    input  logic [1:0]  rd_sel_b,
    output logic        wr_en,
    output reg_idx_t    wr_sel,
    output logic [7:0]  wr_data,
    output logic [1:0]  grant_id,
    output logic        stall,
    output logic        busy
);

    logic [NUM_REQ-1:0] buf_full;
    logic [NUM_REQ-1:0] buf_load;
    logic [NUM_REQ-1:0] buf_clear;
    reg_idx_t           buf_dest [NUM_REQ];
    logic [7:0]         buf_data [NUM_REQ];
    reg_idx_t           in_dest  [NUM_REQ];
    logic [3:0]         pending;
    logic               grant;
    logic [1:0]         grant_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign in_dest[gi]   = req_dest[2*gi +: 2];
            // Ready uses only registered state, so an entry emptied this edge cannot refill on it.
            assign req_ready[gi] = ~buf_full[gi] & ~pending[in_dest[gi]];
            assign buf_load[gi]  = req_valid[gi] & req_ready[gi];
            assign buf_clear[gi] = grant & (grant_sel == 2'(gi));

            regfile_req_buffer u_buf (
                .clock     (clock),
                .reset     (reset),
                .load      (buf_load[gi]),
                .load_dest (in_dest[gi]),
                .load_data (req_data[8*gi +: 8]),
                .clear     (buf_clear[gi]),
                .full      (buf_full[gi]),
                .dest      (buf_dest[gi]),
                .data      (buf_data[gi])
            );
        end
    endgenerate

    // A register stays pending until its write pulse has been presented to the file.
    always_comb begin
        pending = 4'b0000;
        if (wr_en)
            pending[wr_sel] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
            if (buf_full[i])
                pending[buf_dest[i]] = 1'b1;
    end

`ifdef REGFILE_ARB_RR_EN
    logic [1:0] ptr;

    always_comb begin
        logic [1:0] cand;
        grant     = 1'b0;
        grant_sel = 2'd0;
        cand      = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (run && !grant && buf_full[cand]) begin
                grant     = 1'b1;
                grant_sel = cand;
            end
            cand = next_req(cand);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ptr <= 2'd0;
        else if (grant)
            ptr <= next_req(grant_sel);
    end
`else
    // Scan from lowest priority upward so the lowest full index wins.
    always_comb begin
        grant     = 1'b0;
        grant_sel = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (run && buf_full[k]) begin
                grant     = 1'b1;
                grant_sel = 2'(k);
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_sel   <= REG_A;
            wr_data  <= 8'h00;
            grant_id <= 2'd0;
        end else begin
            wr_en <= grant;
            if (grant) begin
                wr_sel   <= buf_dest[grant_sel];
                wr_data  <= buf_data[grant_sel];
                grant_id <= grant_sel;
            end
        end
    end

    assign stall = run & (pending[rd_sel_a] | pending[rd_sel_b]);
    assign busy  = (|buf_full) | wr_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a transaction-level model predicts
// accepts, grants and write pulses; a monitor checks every wr_en pulse against the queue.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [5:0]  req_dest = '0;
    logic [23:0] req_data = '0;
    logic [1:0]  rd_sel_a = '0;
    logic [1:0]  rd_sel_b = '0;
    logic [2:0]  req_ready;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [1:0]  grant_id;
    logic        stall;
    logic        busy;

    regfile_write_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_sel_a  (rd_sel_a),
        .rd_sel_b  (rd_sel_b),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .stall     (stall),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         when;
        logic [1:0] sel;
        logic [7:0] data;
        logic [1:0] id;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: what each requester is holding, plus the register file contents.
    bit         m_full [3];
    logic [1:0] m_dest [3];
    logic [7:0] m_data [3];
    bit         m_we;
    logic [1:0] m_wsel;
    int         m_ptr;
    logic [7:0] m_regs [4];
    logic [7:0] dut_regs [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_pend(input logic [1:0] r);
        bit p = m_we && (m_wsel == r);
        for (int i = 0; i < 3; i++)
            if (m_full[i] && m_dest[i] == r) p = 1'b1;
        return p;
    endfunction

    task automatic drive(input logic [2:0] v, input logic [1:0] d0, d1, d2,
                         input logic [7:0] x0, x1, x2);
        req_valid = v;
        req_dest  = {d2, d1, d0};
        req_data  = {x2, x1, x0};
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input bit do_rst, output logic [2:0] acc);
        logic [2:0] rdy;
        int g;
        int idx;
        #1;
        for (int i = 0; i < 3; i++)
            rdy[i] = !m_full[i] && !m_pend(req_dest[2*i +: 2]);
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("stall", 32'(stall), 32'(run && (m_pend(rd_sel_a) || m_pend(rd_sel_b))));
        check("busy", 32'(busy), 32'(m_full[0] || m_full[1] || m_full[2] || m_we));
        acc = req_valid & rdy;
        if (do_rst) begin
            acc = 3'b000;
            for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
            m_we  = 1'b0;
            m_ptr = 0;
            reset = 1'b1;
        end else begin
            g = -1;
            if (run) begin
                for (int k = 0; k < 3; k++) begin
                    idx = RR ? (m_ptr + k) % 3 : k;
                    if (g < 0 && m_full[idx]) g = idx;
                end
            end
            if (g >= 0) begin
                exp_q.push_back('{cyc + 1, m_dest[g], m_data[g], 2'(g)});
                m_regs[m_dest[g]] = m_data[g];
                m_full[g] = 1'b0;
                m_ptr  = (g + 1) % 3;
                m_we   = 1'b1;
                m_wsel = m_dest[g];
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    m_full[i] = 1'b1;
                    m_dest[i] = req_dest[2*i +: 2];
                    m_data[i] = req_data[8*i +: 8];
                end
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every wr_en pulse must match the oldest expected write, in the predicted cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wr at cycle %0d: got wr_en=1 sel=%0h data=%0h, expected no pulse",
                             cyc, wr_sel, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(e.when));
                    check("wr_sel", 32'(wr_sel), 32'(e.sel));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    dut_regs[wr_sel] = wr_data;
                end
            end else if (exp_q.size() > 0 && exp_q[0].when <= cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                check("missed_wr", 32'(wr_en), 32'(1));
            end
        end
    end

    initial begin
        logic [2:0] acc;
        for (int i = 0; i < 4; i++) begin
            m_regs[i]   = 8'h00;
            dut_regs[i] = 8'h00;
        end
        for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
        m_we = 1'b0; m_wsel = 2'd0; m_ptr = 0;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_wr_sel", 32'(wr_sel), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(7));
        @(negedge clock);
        run = 1'b1;

        // ALU writes B with 0x5A
        drive(3'b001, 2'b01, 2'b00, 2'b00, 8'h5A, 8'h00, 8'h00);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (3) step(0, acc);

        // Three-way burst, single grant to ALU, then a second burst
        drive(3'b111, 2'b00, 2'b10, 2'b11, 8'h11, 8'h22, 8'h33);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (4) step(0, acc);
        drive(3'b001, 2'b00, 2'b00, 2'b00, 8'h44, 8'h00, 8'h00);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        step(0, acc);
        drive(3'b111, 2'b01, 2'b10, 2'b11, 8'h55, 8'h66, 8'h77);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (4) step(0, acc);

        // LOAD pending to C, ALU then targets C and must wait
        drive(3'b010, 2'b00, 2'b10, 2'b00, 8'h00, 8'hC7, 8'h00);
        step(0, acc);
        drive(3'b001, 2'b10, 2'b00, 2'b00, 8'h99, 8'h00, 8'h00);
        for (int t = 0; t < 10; t++) begin
            step(0, acc);
            if (acc[0]) break;
        end
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (3) step(0, acc);

        // Read hazard on D
        rd_sel_a = 2'b11;
        drive(3'b100, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 8'hD0);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (3) step(0, acc);
        rd_sel_a = 2'b00;

        // Halted arbiter holds two buffers, then drains them
        run = 1'b0;
        drive(3'b011, 2'b00, 2'b01, 2'b00, 8'hA1, 8'hB2, 8'h00);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (3) step(0, acc);
        run = 1'b1;
        repeat (4) step(0, acc);

        // Reset in the cycle a grant is being selected
        drive(3'b001, 2'b00, 2'b00, 2'b00, 8'hAB, 8'h00, 8'h00);
        step(0, acc);
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        step(1, acc);
        #1;
        check("rstmid_wr_en", 32'(wr_en), 32'(0));
        check("rstmid_busy", 32'(busy), 32'(0));
        check("rstmid_ready", 32'(req_ready), 32'(7));
        @(negedge clock);
        repeat (2) step(0, acc);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            drive(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
            run      = ($urandom_range(0, 7) != 0);
            rd_sel_a = 2'($urandom);
            rd_sel_b = 2'($urandom);
            step(($urandom_range(0, 63) == 0), acc);
        end
        drive(3'b000, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        run = 1'b1;
        repeat (6) step(0, acc);

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        for (int r = 0; r < 4; r++)
            check("final_reg", 32'(dut_regs[r]), 32'(m_regs[r]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 clock  in  1  system clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 run  in  1  global run enable; grants occur only while high.
REQ-005 req_valid  in  3  per-requester write request (bit 0 ALU, bit 1 LOAD, bit 2 INPUT).
REQ-006 req_dest  in  6  2-bit destination register per requester (00 A, 01 B, 10 C, 11 D), requester i at bits [2i+1:2i].
REQ-007 req_data  in  24  8-bit write data per requester, requester i at bits [8i+7:8i].
REQ-008 req_ready  out  3  per-requester accept indication.
REQ-009 rd_sel_a, rd_sel_b  in  2 each  register-file read selects (c4c5 and c6c7).
REQ-010 wr_en, wr_sel, wr_data  out  1/2/8  register-file write enable (c10), select (c8c9) and data (inp), all registered.
REQ-011 grant_id  out  2  requester index of the current wr_en pulse.
REQ-012 stall  out  1  read-after-write hazard on either read select.
REQ-013 busy  out  1  high while any buffer is full or wr_en is high.

Function
REQ-014 Each requester SHALL own a one-entry holding buffer (full flag, 2-bit dest, 8-bit data).
REQ-015 pending[r] SHALL be high when any full buffer, or an asserted wr_en, targets register r.
REQ-016 req_ready[i] SHALL equal buffer i empty AND NOT pending[req_dest_i] (combinational; WAW ordering by exclusion).
REQ-017 A transfer SHALL occur when req_valid[i] AND req_ready[i] at a posedge; the buffer fills at that edge.
REQ-018 When run=1, each cycle the arbiter SHALL select one full buffer, and at the next posedge drive wr_en=1, wr_sel=dest, wr_data=data, grant_id=i, and empty that buffer.
REQ-019 wr_en SHALL be a single-cycle pulse per grant; wr_en SHALL be 0 in any cycle with no grant at the preceding edge.
REQ-020 Latency: accept at edge N -> wr_en high during cycle N+1 at the earliest -> register file captures at edge N+2.
REQ-021 A buffer emptied at an edge SHALL NOT be refilled at that same edge (req_ready is derived from registered state).
REQ-022 When run=0: no grants, wr_en=0 after the next edge, buffers hold contents, accepts continue, stall=0.
REQ-023 stall SHALL equal run AND (pending[rd_sel_a] OR pending[rd_sel_b]), combinational.
REQ-024 With all three buffers full and run=1, all three SHALL be written in three consecutive cycles.

Reset
REQ-025 Reset SHALL empty all buffers, set the priority pointer to 0, and set wr_en=0, wr_sel=00, wr_data=0x00 and grant_id=0.
REQ-026 Reset asserted mid-operation SHALL discard buffered requests and suppress any wr_en pulse that has not yet been issued.

Configuration
REQ-027 With REGFILE_ARB_RR_EN defined, the arbiter SHALL use round-robin priority: the pointer starts at 0 and becomes (i+1) mod 3 after each grant to i; the search begins at the pointer.
REQ-028 Without REGFILE_ARB_RR_EN, the arbiter SHALL use fixed priority ALU > LOAD > INPUT and SHALL have no pointer state.

Structure
REQ-029 Package regfile_pkg SHALL hold: the reg_idx_t 2-bit type, the constant NUM_REQ=3, the requester enum (REQ_ALU=0, REQ_LOAD=1, REQ_INPUT=2) and register codes REG_A..REG_D.
REQ-030 The holding buffer SHALL be sub-module regfile_req_buffer, instantiated NUM_REQ times.

Verification
REQ-031 Reset; ALU writes dest B, data 0x5A -> wr_en pulses once cycle N+1 with wr_sel=01, wr_data=0x5A, grant_id=0.
REQ-032 All three requesters accept together (dest A, C, D; data 0x11/0x22/0x33) -> grants in order 0,1,2 in consecutive cycles (both modes); then a second burst gives order 1,2,0 in RR mode and 0,1,2 in fixed mode after a single grant to 0.
REQ-033 LOAD is pending to C; ALU then requests dest C -> req_ready[0]=0 until the C write pulse completes, and the final C value is the ALU data.
REQ-034 Buffer to D full, rd_sel_a=11 -> stall=1; stall clears after the D wr_en cycle; with rd_sel=00 -> stall=0.
REQ-035 run=0 with two full buffers -> no wr_en and stall=0; run=1 -> two pulses follow.
REQ-036 Reset asserted the same cycle a grant is selected -> no wr_en pulse, busy=0, all req_ready=1.
